// File: rtl/vga_timing_pattern_gen_if.sv
// vga_timing_pattern_gen_if: pattern controls in, timing/video outputs back to the pin driver or pixel source
interface vga_timing_pattern_gen_if #(
    parameter int CNT_W = 10,
    parameter int PIX_W = 4
);
    logic [1:0]       mode;
    logic             invert;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;
    logic [PIX_W-1:0] video;
    modport master (
        input  mode, invert,
        output hsync, vsync, de, x, y, line_start, frame_start, video
    );
    modport slave (
        output mode, invert,
        input  hsync, vsync, de, x, y, line_start, frame_start, video
    );
endinterface

// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen: programmable VGA timing with aligned sync/de/coords/pulses and a grey test pattern
module vga_timing_pattern_gen #(
    parameter int H_DISPLAY     = 640,
    parameter int H_FRONT_PORCH = 16,
    parameter int H_SYNC_PULSE  = 96,
    parameter int H_BACK_PORCH  = 48,
    parameter int V_DISPLAY     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter bit HS_POL        = 1'b0,
    parameter bit VS_POL        = 1'b0,
    parameter int CNT_W         = 10,
    parameter int PIX_W         = 4,
    parameter int CHK_LOG2      = 5,
    parameter int RAMP_SHIFT    = 6
) (
    input logic clk_25mhz,
    input logic reset,
    vga_timing_pattern_gen_if.master vif
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_DISPLAY - 1);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_DISPLAY - 1);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_DISPLAY + H_FRONT_PORCH);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_DISPLAY + V_FRONT_PORCH);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, x_d, y_q, y_d;
    logic [1:0]       mode_q, mode_d;
    logic             invert_q, invert_d;
    logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic             line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic [PIX_W-1:0] video_q, video_d, pattern;
    logic             h_wrap, v_wrap, chk, border;

    always_comb begin
        h_wrap        = h_cnt_q == H_LAST;
        v_wrap        = v_cnt_q == V_LAST;
        h_cnt_d       = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d       = h_wrap ? (v_wrap ? '0 : v_cnt_q + 1'b1) : v_cnt_q;
        // settings swap on the last pixel so the whole next frame uses them
        mode_d        = (h_wrap && v_wrap) ? vif.mode : mode_q;
        invert_d      = (h_wrap && v_wrap) ? vif.invert : invert_q;
        x_d           = h_cnt_q;
        y_d           = v_cnt_q;
        de_d          = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_d       = (h_cnt_q >= H_SS && h_cnt_q < H_SE) ? HS_POL : ~HS_POL;
        vsync_d       = (v_cnt_q >= V_SS && v_cnt_q < V_SE) ? VS_POL : ~VS_POL;
        line_start_d  = h_cnt_q == '0;
        frame_start_d = h_cnt_q == '0 && v_cnt_q == '0;
        chk           = |(((h_cnt_q ^ v_cnt_q) >> CHK_LOG2) & CNT_W'(1));
        border        = h_cnt_q == '0 || h_cnt_q == H_END || v_cnt_q == '0 || v_cnt_q == V_END;
        pattern       = mode_q == 2'd0 ? {PIX_W{1'b1}} :
                        mode_q == 2'd1 ? {PIX_W{chk}} :
                        mode_q == 2'd2 ? PIX_W'(h_cnt_q >> RAMP_SHIFT) :
                                         {PIX_W{border}};
        video_d       = de_d ? (invert_q ? ~pattern : pattern) : '0;
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            mode_q        <= '0;
            invert_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            video_q       <= '0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            mode_q        <= mode_d;
            invert_q      <= invert_d;
            x_q           <= x_d;
            y_q           <= y_d;
            de_q          <= de_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            video_q       <= video_d;
        end
    end

    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.de          = de_q;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = line_start_q;
    assign vif.frame_start = frame_start_q;
    assign vif.video       = video_q;
endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb_vga_timing_pattern_gen: random and directed checks of a reduced-size generator against a pixel-index model
module tb_vga_timing_pattern_gen;
    localparam int HD = 64, HF = 4, HSP = 8, HB = 4;
    localparam int VD = 40, VF = 2, VSP = 2, VB = 3;
    localparam int HT = HD + HF + HSP + HB;
    localparam int VT = VD + VF + VSP + VB;
    localparam int FT = HT * VT;
    localparam logic [24:0] RST_VEC = {7'd0, 7'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_pattern_gen_if #(.CNT_W(7), .PIX_W(4)) vif();
    vga_timing_pattern_gen_if #(.CNT_W(4), .PIX_W(4)) sif();

    vga_timing_pattern_gen #(
        .H_DISPLAY(HD), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(HSP), .H_BACK_PORCH(HB),
        .V_DISPLAY(VD), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(VSP), .V_BACK_PORCH(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(7), .PIX_W(4), .CHK_LOG2(3), .RAMP_SHIFT(2)
    ) dut (.clk_25mhz(clk), .reset(rst), .vif(vif));

    vga_timing_pattern_gen #(
        .H_DISPLAY(8), .H_FRONT_PORCH(2), .H_SYNC_PULSE(2), .H_BACK_PORCH(2),
        .V_DISPLAY(4), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4), .PIX_W(4), .CHK_LOG2(2), .RAMP_SHIFT(1)
    ) dut_small (.clk_25mhz(clk), .reset(rst), .vif(sif));

    int tests = 0, fails = 0;
    int n = 0;
    logic [1:0] em = 2'd0, lm = 2'd0;
    logic ei = 1'b0, li = 1'b0;
    int ex, ey;
    logic ede, ehs, evs, els, efs;
    logic [3:0] evid;

    function automatic logic [24:0] obs();
        return {vif.x, vif.y, vif.de, vif.hsync, vif.vsync, vif.line_start, vif.frame_start, vif.video};
    endfunction

    function automatic logic [24:0] expv();
        return {7'(ex), 7'(ey), ede, ehs, evs, els, efs, evid};
    endfunction

    // output on edge p after reset describes pixel p of an endless raster
    function automatic void model(int p);
        int px, py;
        logic [3:0] pat;
        px   = p % HT;
        py   = (p / HT) % VT;
        ex   = px;
        ey   = py;
        ede  = px < HD && py < VD;
        ehs  = !(px >= HD + HF && px < HD + HF + HSP);
        evs  = !(py >= VD + VF && py < VD + VF + VSP);
        els  = px == 0;
        efs  = px == 0 && py == 0;
        case (em)
            2'd0: pat = 4'd15;
            2'd1: pat = ((px / 8 + py / 8) % 2) != 0 ? 4'd15 : 4'd0;
            2'd2: pat = 4'((px / 4) % 16);
            default: pat = (px == 0 || px == HD - 1 || py == 0 || py == VD - 1) ? 4'd15 : 4'd0;
        endcase
        evid = !ede ? 4'd0 : (ei ? 4'(15 - pat) : pat);
    endfunction

    task automatic tick();
        logic [1:0] sm;
        logic si;
        @(posedge clk);
        sm = vif.mode;
        si = vif.invert;
        #1;
        if (n > 0 && n % FT == 0) begin
            em = lm;
            ei = li;
        end
        if (n % FT == FT - 1) begin
            lm = sm;
            li = si;
        end
        model(n);
        n++;
    endtask

    task automatic run_to(input int a, input int b);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(ex == a && ey == b) && k <= FT + 1);
        if (k > FT + 1) begin
            tests++;
            fails++;
            $display("FAIL run_to (%0d,%0d) not reached in %0d cycles", a, b, k);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        em = 2'd0;
        ei = 1'b0;
        lm = 2'd0;
        li = 1'b0;
    endtask

    task automatic test_reset();
        vif.mode = 2'd2;
        vif.invert = 1'b1;
        sif.mode = 2'd0;
        sif.invert = 1'b0;
        @(negedge clk);
        #2;
        tests++;
        if (obs() !== RST_VEC) begin
            fails++;
            $display("FAIL reset_values got=%h exp=%h", obs(), RST_VEC);
        end
        tests++;
        if ({sif.hsync, sif.vsync, sif.de, sif.video} !== 7'b0) begin
            fails++;
            $display("FAIL reset_small_pol got=%b exp=0", {sif.hsync, sif.vsync, sif.de, sif.video});
        end
        release_reset();
    endtask

    task automatic test_first_pixel();
        tick();
        tests++;
        if (vif.x !== 7'd0 || vif.y !== 7'd0 || vif.frame_start !== 1'b1 || vif.line_start !== 1'b1) begin
            fails++;
            $display("FAIL first_pixel got x=%0d y=%0d fs=%b ls=%b exp 0 0 1 1", vif.x, vif.y, vif.frame_start, vif.line_start);
        end
        tests++;
        if (vif.video !== 4'd15) begin
            fails++;
            $display("FAIL first_video got=%0d exp=15 (mode 0 after reset)", vif.video);
        end
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 2 * FT; i++) begin
            if ($urandom_range(199) == 0) begin
                vif.mode = 2'($urandom_range(3));
                vif.invert = 1'($urandom_range(1));
            end
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL frame_px n=%0d got=%h exp=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_sync_timing();
        logic ph, pv;
        int hfalls = 0, hbad = 0, hlow = 0, hrun = 0, vfalls = 0, vbad = 0, vlow = 0, fsc = 0, lsc = 0;
        tick();
        ph = vif.hsync;
        pv = vif.vsync;
        for (int i = 0; i < FT; i++) begin
            tick();
            if (ph && !vif.hsync) begin
                hfalls++;
                if (vif.x !== 7'(HD + HF)) hbad++;
            end
            if (!ph && vif.hsync && hrun != HSP && hrun != 0) hbad++;
            hrun = vif.hsync ? 0 : hrun + 1;
            if (!vif.hsync) hlow++;
            if (pv && !vif.vsync) begin
                vfalls++;
                if (vif.y !== 7'(VD + VF) || vif.x !== 7'd0) vbad++;
            end
            if (!vif.vsync) vlow++;
            if (vif.frame_start) fsc++;
            if (vif.line_start) lsc++;
            ph = vif.hsync;
            pv = vif.vsync;
        end
        tests++;
        if (hfalls != VT || hbad != 0 || hlow != HSP * VT) begin
            fails++;
            $display("FAIL hsync_window falls=%0d bad=%0d low=%0d exp %0d 0 %0d", hfalls, hbad, hlow, VT, HSP * VT);
        end
        tests++;
        if (vfalls != 1 || vbad != 0 || vlow != VSP * HT) begin
            fails++;
            $display("FAIL vsync_window falls=%0d bad=%0d low=%0d exp 1 0 %0d", vfalls, vbad, vlow, VSP * HT);
        end
        tests++;
        if (fsc != 1 || lsc != VT) begin
            fails++;
            $display("FAIL pulse_counts fs=%0d ls=%0d exp 1 %0d", fsc, lsc, VT);
        end
    endtask

    task automatic test_mode_switch();
        int bad = 0, k = 0;
        vif.mode = 2'd1;
        vif.invert = 1'b0;
        run_to(0, 0);
        tests++;
        if (vif.video !== 4'd0) begin fails++; $display("FAIL chk_0_0 got=%0d exp=0", vif.video); end
        run_to(8, 0);
        tests++;
        if (vif.video !== 4'd15) begin fails++; $display("FAIL chk_8_0 got=%0d exp=15", vif.video); end
        run_to(8, 8);
        tests++;
        if (vif.video !== 4'd0) begin fails++; $display("FAIL chk_8_8 got=%0d exp=0", vif.video); end
        run_to(50, 20);
        vif.mode = 2'd3;
        do begin
            tick();
            k++;
            if (!efs && (vif.video !== evid || em != 2'd1)) bad++;
        end while (!efs && k <= FT);
        tests++;
        if (bad != 0 || k > FT) begin
            fails++;
            $display("FAIL switch_keeps_checker bad=%0d cycles=%0d exp bad=0", bad, k);
        end
        tests++;
        if (vif.frame_start !== 1'b1 || vif.video !== 4'd15) begin
            fails++;
            $display("FAIL border_0_0 got fs=%b video=%0d exp 1 15", vif.frame_start, vif.video);
        end
        run_to(1, 1);
        tests++;
        if (vif.video !== 4'd0) begin fails++; $display("FAIL border_1_1 got=%0d exp=0", vif.video); end
    endtask

    task automatic test_ramp_invert();
        vif.mode = 2'd2;
        vif.invert = 1'b0;
        run_to(0, 0);
        run_to(3, 0);
        tests++;
        if (vif.video !== 4'd0) begin fails++; $display("FAIL ramp_3 got=%0d exp=0", vif.video); end
        run_to(4, 0);
        tests++;
        if (vif.video !== 4'd1) begin fails++; $display("FAIL ramp_4 got=%0d exp=1", vif.video); end
        run_to(HD - 1, 0);
        tests++;
        if (vif.video !== 4'd15) begin fails++; $display("FAIL ramp_last got=%0d exp=15", vif.video); end
        tick();
        tests++;
        if (vif.de !== 1'b0 || vif.video !== 4'd0 || vif.x !== 7'(HD)) begin
            fails++;
            $display("FAIL ramp_blank got de=%b video=%0d x=%0d exp 0 0 %0d", vif.de, vif.video, vif.x, HD);
        end
        vif.invert = 1'b1;
        run_to(0, 0);
        tests++;
        if (vif.video !== 4'd15) begin fails++; $display("FAIL inv_ramp_0 got=%0d exp=15", vif.video); end
        run_to(HD + 6, 5);
        tests++;
        if (vif.video !== 4'd0) begin fails++; $display("FAIL inv_blank got=%0d exp=0", vif.video); end
    endtask

    task automatic test_mid_reset();
        int wait_cycles;
        vif.mode = 2'($urandom_range(3));
        vif.invert = 1'($urandom_range(1));
        wait_cycles = $urandom_range(FT - 1, 200);
        repeat (wait_cycles) tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs() !== RST_VEC) begin
            fails++;
            $display("FAIL async_reset got=%h exp=%h", obs(), RST_VEC);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (obs() !== RST_VEC) begin
            fails++;
            $display("FAIL reset_hold got=%h exp=%h", obs(), RST_VEC);
        end
        release_reset();
        for (int i = 0; i < HT * 3; i++) begin
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("FAIL post_reset_px n=%0d got=%h exp=%h", n, obs(), expv());
            end
        end
    endtask

    task automatic test_small();
        int k = 0, ls = 0, hh = 0, hbad = 0, vh = 0, vbad = 0, mx = 0, my = 0;
        do begin
            tick();
            k++;
        end while (sif.frame_start !== 1'b1 && k < 200);
        tests++;
        if (k >= 200) begin fails++; $display("FAIL small_fs_timeout got=%0d cycles exp<200", k); end
        k = 0;
        do begin
            if (sif.line_start) ls++;
            if (sif.hsync) begin hh++; if (sif.x !== 4'd10 && sif.x !== 4'd11) hbad++; end
            if (sif.vsync) begin vh++; if (sif.y !== 4'd5) vbad++; end
            if (int'(sif.x) > mx) mx = int'(sif.x);
            if (int'(sif.y) > my) my = int'(sif.y);
            tick();
            k++;
        end while (sif.frame_start !== 1'b1 && k < 200);
        tests++;
        if (k != 98 || ls != 7) begin fails++; $display("FAIL small_frame got len=%0d lines=%0d exp 98 7", k, ls); end
        tests++;
        if (hh != 14 || hbad != 0 || vh != 14 || vbad != 0) begin
            fails++;
            $display("FAIL small_sync got hh=%0d hbad=%0d vh=%0d vbad=%0d exp 14 0 14 0", hh, hbad, vh, vbad);
        end
        tests++;
        if (mx != 13 || my != 6) begin fails++; $display("FAIL small_wrap got max x=%0d y=%0d exp 13 6", mx, my); end
    endtask

    initial begin
        test_reset();
        test_first_pixel();
        test_random_frames();
        test_sync_timing();
        test_mode_switch();
        test_ramp_invert();
        test_mid_reset();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
